// File: rtl/lstm_pkg.sv
// Shared LSTM definitions: FSM state encoding and default layer dimensions,
// used by the forward sequencer and the address generators.
package lstm_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MAC_X = 3'd1;
  localparam logic [2:0] ST_MAC_H = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_ACT   = 3'd4;
  localparam logic [2:0] ST_WRITE = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_MAC_X = ST_MAC_X,
    S_MAC_H = ST_MAC_H,
    S_DRAIN = ST_DRAIN,
    S_ACT   = ST_ACT,
    S_WRITE = ST_WRITE,
    S_DONE  = ST_DONE
  } fwd_state_e;

  localparam int DEF_NUM_CELL  = 53;
  localparam int DEF_NUM_INPUT = 53;
  localparam int DEF_TIMESTEP  = 7;
  localparam int DEF_DELAY     = 2;
  localparam int DEF_ACT_LAT   = 3;
  localparam int DEF_CNT_WIDTH = 12;

endpackage

// File: rtl/lstm_phase_cnt.sv
// Loadable down-counter with terminal-count flag; hold freezes it entirely,
// taking priority over load.
module lstm_phase_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!hold) begin
      if (load)             cnt <= load_val;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/lstm_fwd_ctrl.sv
// LSTM forward-pass sequencer: walks cells x timesteps through MAC_X, MAC_H,
// DRAIN, ACT, WRITE. Optional stall input enabled by LSTM_FWD_CTRL_STALL_EN.
module lstm_fwd_ctrl
  import lstm_pkg::*;
#(
  parameter int NUM_CELL  = DEF_NUM_CELL,
  parameter int NUM_INPUT = DEF_NUM_INPUT,
  parameter int TIMESTEP  = DEF_TIMESTEP,
  parameter int DELAY     = DEF_DELAY,
  parameter int ACT_LAT   = DEF_ACT_LAT,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef LSTM_FWD_CTRL_STALL_EN
  input  logic                 i_stall,
`endif
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_en_x,
  output logic                 o_en_h,
  output logic                 o_acc_clr,
  output logic                 o_act_en,
  output logic                 o_wr_en,
  output logic [CNT_WIDTH-1:0] o_cell,
  output logic [CNT_WIDTH-1:0] o_tstep
);

  localparam logic [CNT_WIDTH-1:0] LEN_X     = CNT_WIDTH'(NUM_INPUT - 1);
  localparam logic [CNT_WIDTH-1:0] LEN_H     = CNT_WIDTH'(NUM_CELL - 1);
  localparam logic [CNT_WIDTH-1:0] LEN_D     = CNT_WIDTH'(DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] LEN_A     = CNT_WIDTH'(ACT_LAT - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CELL = CNT_WIDTH'(NUM_CELL - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_TS   = CNT_WIDTH'(TIMESTEP - 1);

  fwd_state_e           state, next_state;
  logic                 stall;
  logic                 cnt_load, cnt_tc;
  logic [CNT_WIDTH-1:0] cnt_val, cnt_load_val;
  logic [CNT_WIDTH-1:0] cell_q, tstep_q;
  logic                 last_cell, last_ts;

`ifdef LSTM_FWD_CTRL_STALL_EN
  assign stall = i_stall;
`else
  assign stall = 1'b0;
`endif

  assign last_cell = (cell_q == LAST_CELL);
  assign last_ts   = (tstep_q == LAST_TS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    next_state   = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      S_IDLE:  if (start)  next_state = S_MAC_X;
      S_MAC_X: if (cnt_tc) next_state = (tstep_q != '0) ? S_MAC_H : S_DRAIN;
      S_MAC_H: if (cnt_tc) next_state = S_DRAIN;
      S_DRAIN: if (cnt_tc) next_state = S_ACT;
      S_ACT:   if (cnt_tc) next_state = S_WRITE;
      S_WRITE: next_state = (last_cell && last_ts) ? S_DONE : S_MAC_X;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (stall) next_state = state;

    // Each phase starts at length-1 and ends on terminal count.
    cnt_load = (next_state != state);
    case (next_state)
      S_MAC_X: cnt_load_val = LEN_X;
      S_MAC_H: cnt_load_val = LEN_H;
      S_DRAIN: cnt_load_val = LEN_D;
      S_ACT:   cnt_load_val = LEN_A;
      default: cnt_load_val = '0;
    endcase
  end

  lstm_phase_cnt #(.W(CNT_WIDTH)) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (stall),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .cnt      (cnt_val),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_q  <= '0;
      tstep_q <= '0;
    end else if (!stall) begin
      if (state == S_IDLE && start) begin
        cell_q  <= '0;
        tstep_q <= '0;
      end else if (state == S_WRITE) begin
        if (!last_cell) begin
          cell_q <= cell_q + 1'b1;
        end else if (!last_ts) begin
          cell_q  <= '0;
          tstep_q <= tstep_q + 1'b1;
        end
      end
    end
  end

  assign o_busy    = (state != S_IDLE) && (state != S_DONE);
  assign o_done    = (state == S_DONE);
  assign o_en_x    = (state == S_MAC_X) && !stall;
  assign o_en_h    = (state == S_MAC_H) && !stall;
  assign o_acc_clr = (state == S_MAC_X) && (cnt_val == LEN_X) && !stall;
  assign o_act_en  = (state == S_ACT) && (cnt_val == LEN_A) && !stall;
  assign o_wr_en   = (state == S_WRITE) && !stall;
  assign o_cell    = cell_q;
  assign o_tstep   = tstep_q;

endmodule

// File: tb/tb_lstm_fwd_ctrl.sv
// Self-checking bench for lstm_fwd_ctrl: small-configuration passes with a
// write-back scoreboard, plus one full pass at default dimensions.
module tb_lstm_fwd_ctrl;

  localparam int NC = 2, NI = 3, TS = 2, DL = 2, AL = 1, CW = 12;
  localparam int PASS_CYC = NC * (TS * (NI + DL + AL + 1) + (TS - 1) * NC);
  localparam int DEF_CYC  = 53 * (7 * (53 + 2 + 3 + 1) + 6 * 53);

  typedef struct { int t; int c; } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, d_rst_n, s_start, d_start, s_stall;
  logic s_busy, s_done, s_en_x, s_en_h, s_acc_clr, s_act_en, s_wr_en;
  logic d_busy, d_done, d_en_x, d_en_h, d_acc_clr, d_act_en, d_wr_en;
  logic [CW-1:0] s_cell, s_tstep, d_cell, d_tstep;

  int  errors = 0, checks = 0;
  wr_t exp_q[$];
  int  busy_cnt, x_cnt, h_cnt, clr_cnt, wr_cnt, clr_bad, h_bad, excl_bad;
  int  d_busy_cnt = 0;
  logic prev_x;

  lstm_fwd_ctrl #(.NUM_CELL(NC), .NUM_INPUT(NI), .TIMESTEP(TS), .DELAY(DL),
                  .ACT_LAT(AL), .CNT_WIDTH(CW)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start),
`ifdef LSTM_FWD_CTRL_STALL_EN
    .i_stall(s_stall),
`endif
    .o_busy(s_busy), .o_done(s_done), .o_en_x(s_en_x), .o_en_h(s_en_h),
    .o_acc_clr(s_acc_clr), .o_act_en(s_act_en), .o_wr_en(s_wr_en),
    .o_cell(s_cell), .o_tstep(s_tstep)
  );

  lstm_fwd_ctrl u_default (
    .clk(clk), .rst_n(d_rst_n), .start(d_start),
`ifdef LSTM_FWD_CTRL_STALL_EN
    .i_stall(1'b0),
`endif
    .o_busy(d_busy), .o_done(d_done), .o_en_x(d_en_x), .o_en_h(d_en_h),
    .o_acc_clr(d_acc_clr), .o_act_en(d_act_en), .o_wr_en(d_wr_en),
    .o_cell(d_cell), .o_tstep(d_tstep)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each write.
  always @(negedge clk) begin
    wr_t e;
    if (s_busy)  busy_cnt++;
    if (s_en_x)  x_cnt++;
    if (s_en_h) begin
      h_cnt++;
      if (s_tstep != CW'(1)) h_bad++;
    end
    if (s_acc_clr) begin
      clr_cnt++;
      if (!(s_en_x && !prev_x)) clr_bad++;
    end
    if (32'(s_en_x) + 32'(s_en_h) + 32'(s_act_en) + 32'(s_wr_en) > 1) excl_bad++;
    if (s_wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_tstep", 32'(s_tstep), e.t);
        check("wr_cell", 32'(s_cell), e.c);
      end
    end
    prev_x = s_en_x;
    if (d_busy) d_busy_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    busy_cnt = 0; x_cnt = 0; h_cnt = 0; clr_cnt = 0; wr_cnt = 0;
    clr_bad = 0; h_bad = 0; excl_bad = 0;
  endtask

  task automatic push_expected();
    for (int t = 0; t < TS; t++)
      for (int c = 0; c < NC; c++)
        exp_q.push_back('{t: t, c: c});
  endtask

  task automatic launch(input string tag);
    push_expected();
    s_start = 1'b1;
    step();
    check({tag, "_first_busy"}, 32'(s_busy), 32'd1);
    check({tag, "_first_en_x"}, 32'(s_en_x), 32'd1);
    check({tag, "_first_clr"}, 32'(s_acc_clr), 32'd1);
    s_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!s_done && n < 400) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, 32'(s_done), 32'd1);
  endtask

  task automatic check_pass(input string tag, input int exp_busy);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_en_x_cycles"}, x_cnt, NC * TS * NI);
    check({tag, "_en_h_cycles"}, h_cnt, NC * (TS - 1) * NC);
    check({tag, "_acc_clr"}, clr_cnt, NC * TS);
    check({tag, "_wr_pulses"}, wr_cnt, NC * TS);
    check({tag, "_clr_not_at_rise"}, clr_bad, 0);
    check({tag, "_en_h_wrong_ts"}, h_bad, 0);
    check({tag, "_enables_overlap"}, excl_bad, 0);
    check({tag, "_scoreboard_left"}, exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(s_busy), 0);
    check({tag, "_done"}, 32'(s_done), 0);
    check({tag, "_en_x"}, 32'(s_en_x), 0);
    check({tag, "_en_h"}, 32'(s_en_h), 0);
    check({tag, "_acc_clr"}, 32'(s_acc_clr), 0);
    check({tag, "_act_en"}, 32'(s_act_en), 0);
    check({tag, "_wr_en"}, 32'(s_wr_en), 0);
    check({tag, "_cell"}, 32'(s_cell), 0);
    check({tag, "_tstep"}, 32'(s_tstep), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; d_rst_n = 1'b0; s_start = 1'b0; d_start = 1'b0; s_stall = 1'b0;
    prev_x = 1'b0;
    clear_counts();
    #23;
    rst_n = 1'b1; d_rst_n = 1'b1;
    step();
    check_idle_outputs("reset");

    // Long default-dimension pass runs in the background.
    d_start = 1'b1;
    step();
    check("dflt_first_busy", 32'(d_busy), 1);
    d_start = 1'b0;

    // Plain single pass.
    clear_counts();
    launch("p1");
    wait_done("p1");
    check_pass("p1", PASS_CYC);
    step();
    check("p1_done_one_cycle", 32'(s_done), 0);
    check("p1_final_cell", 32'(s_cell), NC - 1);
    check("p1_final_tstep", 32'(s_tstep), TS - 1);

    // start pulses during MAC_H and during DONE are ignored.
    clear_counts();
    launch("p2");
    n = 0;
    while (!s_en_h && n < 100) begin step(); n++; end
    check("p2_reached_mac_h", 32'(s_en_h), 1);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    wait_done("p2");
    check_pass("p2", PASS_CYC);
    s_start = 1'b1;
    step();
    check("p2_ignore_in_done", 32'(s_busy), 0);
    s_start = 1'b0;
    step();
    check("p2_stays_idle", 32'(s_busy), 0);

    // start held high relaunches on the IDLE cycle after DONE.
    clear_counts();
    launch("p3");
    s_start = 1'b1;
    wait_done("p3");
    check_pass("p3", PASS_CYC);
    clear_counts();
    push_expected();
    step();
    check("p3_idle_gap", 32'(s_busy), 0);
    step();
    check("p3_relaunch", 32'(s_busy), 1);
    s_start = 1'b0;

    // Reset during ACT of cell 1 (busy cycle 13), then a fresh full pass.
    n = 0;
    while (busy_cnt < 13 && n < 100) begin step(); n++; end
    check("rst_at_act_cell", 32'(s_cell), 1);
    check("rst_at_act_en", 32'(s_act_en), 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    clear_counts();
    launch("p4");
    wait_done("p4");
    check_pass("p4", PASS_CYC);

`ifdef LSTM_FWD_CTRL_STALL_EN
    // Five stall cycles inside MAC_X of the first cell.
    step();
    clear_counts();
    launch("p5");
    step();
    s_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_en_x_low", 32'(s_en_x), 0);
      check("stall_busy_high", 32'(s_busy), 1);
    end
    s_stall = 1'b0;
    wait_done("p5");
    check_pass("p5", PASS_CYC + 5);
`endif

    // Default-dimension pass completion.
    n = 0;
    while (!d_done && n < 45000) begin step(); n++; end
    check("dflt_done_seen", 32'(d_done), 1);
    check("dflt_busy_cycles", d_busy_cnt, DEF_CYC);
    check("dflt_final_cell", 32'(d_cell), 52);
    check("dflt_final_tstep", 32'(d_tstep), 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lstm_fwd_ctrl.md
# lstm_fwd_ctrl

Forward-propagation sequencer for the LSTM core. Accepts one start request and walks every cell of every timestep through a fixed set of phases: input MAC, recurrent MAC, pipeline drain, activation and write-back. Its enables drive the X and H read-address generators, the MAC accumulators, the activation unit and the state write port. It sits between the top-level training controller and the forward datapath.

## Interface
- NUM_CELL, 53: hidden cells per layer
- NUM_INPUT, 53: input features per timestep
- TIMESTEP, 7: timesteps per sequence
- DELAY, 2: MAC pipeline latency in cycles; must be ≥ 1
- ACT_LAT, 3: activation unit latency in cycles; must be ≥ 1
- CNT_WIDTH, 12: width of the cell and timestep index outputs
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous assertion, active-low
- start  in  1  request a forward pass; sampled only in IDLE
- o_busy  out  1  high from the first cycle after start is accepted until the DONE cycle (exclusive)
- o_done  out  1  one-cycle pulse in the DONE state
- o_en_x  out  1  enable to the X address generator and MAC, input phase
- o_en_h  out  1  enable to the H address generator and MAC, recurrent phase
- o_acc_clr  out  1  clear MAC accumulators; first cycle of each cell
- o_act_en  out  1  launch activation; first cycle of ACT
- o_wr_en  out  1  write c/h for the current cell
- o_cell  out  CNT_WIDTH  current cell index, 0..NUM_CELL-1
- o_tstep  out  CNT_WIDTH  current timestep, 0..TIMESTEP-1

## Operation
- States: IDLE, MAC_X, MAC_H, DRAIN, ACT, WRITE, DONE.
- All outputs are Moore outputs decoded from registered state and counters. No combinational path runs from start to any output.
- IDLE: when start=1, go to MAC_X and clear o_cell, o_tstep and the phase counter.
- MAC_X: lasts NUM_INPUT cycles with o_en_x=1. o_acc_clr=1 only in its first cycle. At the end, go to MAC_H if o_tstep>0, otherwise go to DRAIN.
- MAC_H: lasts NUM_CELL cycles with o_en_h=1. It is skipped at timestep 0 because h(-1)=0.
- DRAIN: lasts DELAY cycles with all enables low.
- ACT: lasts ACT_LAT cycles. o_act_en=1 only in its first cycle.
- WRITE: lasts 1 cycle with o_wr_en=1, then:
  - if o_cell<NUM_CELL-1: increment o_cell and go to MAC_X;
  - else if o_tstep<TIMESTEP-1: set o_cell to 0, increment o_tstep and go to MAC_X;
  - else go to DONE.
- DONE: lasts 1 cycle with o_done=1 and o_busy=0, then returns to IDLE. o_cell and o_tstep hold their final values until the next start.
- start outside IDLE is ignored. start held high re-launches on the IDLE cycle after DONE.
- One shared phase counter, CNT_WIDTH wide, counts down from phase length minus 1. It reloads on every state change.
- At most one of o_en_x, o_en_h, o_act_en, o_wr_en is high in any cycle.

## Timing
- Reset values: state=IDLE; all 1-bit outputs 0; o_cell=0; o_tstep=0; phase counter 0.
- The first MAC_X cycle (o_busy=1, o_en_x=1, o_acc_clr=1) is the cycle after the edge that samples start.
- Cycles per cell:
  - at timestep 0: NUM_INPUT+DELAY+ACT_LAT+1;
  - at later timesteps: add NUM_CELL.
- o_busy cycles = NUM_CELL·[TIMESTEP·(NUM_INPUT+DELAY+ACT_LAT+1) + (TIMESTEP-1)·NUM_CELL]. o_done follows in the next cycle.
- Reset asserted mid-pass returns the block to reset values immediately. No pulse completes.

## Configuration
- LSTM_FWD_CTRL_STALL_EN defined: adds input i_stall (1 bit).
  - While i_stall=1 outside IDLE, state, counters and indices freeze, and o_en_x, o_en_h, o_acc_clr, o_act_en, o_wr_en are forced to 0. The frozen cycle is replayed once i_stall falls.
  - In IDLE, i_stall blocks acceptance of start.
- Not defined: there is no port, and the block behaves as if i_stall=0.

## Structure
- Shared package lstm_pkg holds the state encoding (localparams for the 7 states, 3-bit) and the default dimension parameters, which are shared with the address generators.
- One natural sub-module, lstm_phase_cnt: a loadable down-counter with terminal-count flag and a hold input for the stall. The FSM and index counters stay in lstm_fwd_ctrl.

## Test plan
- Small configuration NUM_CELL=2, NUM_INPUT=3, TIMESTEP=2, DELAY=2, ACT_LAT=1, single start pulse:
  - o_busy high for exactly 32 cycles, then o_done high for 1 cycle;
  - 4 o_wr_en pulses, with (o_tstep,o_cell) = (0,0),(0,1),(1,0),(1,1).
- Same configuration: o_en_x high for 12 cycles total; o_en_h high for 4 cycles total, all within timestep 1; o_acc_clr pulses 4 times, each coinciding with an o_en_x rising edge.
- start re-pulsed during MAC_H and during DONE: ignored; o_busy count unchanged.
- rst_n pulled low in ACT of cell 1: all outputs 0 asynchronously; a fresh start afterwards gives a full 32-cycle pass.
- With LSTM_FWD_CTRL_STALL_EN, i_stall held 5 cycles mid MAC_X: enables low during the stall; total o_busy = 37 cycles; o_en_x total still 12.
- Default parameters: o_busy = 53·(7·59 + 6·53) = 38743 cycles; final o_cell=52, o_tstep=6.
